// File: rtl/if_defs_pkg.sv
// Shared definitions for the fetch-stage PC sequencer: FSM state encodings
// and the default sequential step / reset PC.
package if_defs;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    FETCH    = 2'd1,
    STALLED  = 2'd2,
    HALTED   = 2'd3
  } state_t;

  localparam int          DEF_PC_STEP  = 4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/if_pc_sequencer_adder.sv
// B-wide modulo-2^B adder used for the sequential PC increment.
module if_pc_sequencer_adder #(
  parameter int B = 32
) (
  input  logic [B-1:0] i_a,
  input  logic [B-1:0] i_b,
  output logic [B-1:0] o_sum
);

  assign o_sum = i_a + i_b;

endmodule

// File: rtl/if_pc_sequencer.sv
// Fetch-stage PC owner and instruction-memory handshake controller.
// Optional halt input and HALTED state are enabled by defining IF_PC_HALT_EN.
module if_pc_sequencer
  import if_defs::*;
#(
  parameter int           B        = 32,
  parameter int           PC_STEP  = DEF_PC_STEP,
  parameter logic [B-1:0] RESET_PC = B'(DEF_RESET_PC)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         stall,
  input  logic         redirect,
  input  logic [B-1:0] redirect_target,
  input  logic         imem_ack,
`ifdef IF_PC_HALT_EN
  input  logic         halt,
`endif
  output logic         imem_req,
  output logic [B-1:0] imem_addr,
  output logic         fetch_valid,
  output logic [B-1:0] fetch_pc,
  output logic [B-1:0] fetch_pc_next
);

  localparam logic [B-1:0] STEP_W     = B'(PC_STEP);
  localparam logic [B-1:0] ALIGN_MASK = ~(STEP_W - B'(1));

  state_t       r_state;
  logic [B-1:0] r_pc;
  logic         r_fetch_valid;
  logic [B-1:0] r_fetch_pc;
  logic [B-1:0] r_fetch_pc_next;

  logic [B-1:0] w_pc_sum;
  logic [B-1:0] w_target;
  logic         w_halt;

`ifdef IF_PC_HALT_EN
  assign w_halt = halt;
`else
  assign w_halt = 1'b0;
`endif

  // One adder result serves both the next PC and the link address.
  if_pc_sequencer_adder #(.B(B)) u_adder (
    .i_a   (r_pc),
    .i_b   (STEP_W),
    .o_sum (w_pc_sum)
  );

  assign w_target = redirect_target & ALIGN_MASK;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= RST_WAIT;
      r_pc            <= RESET_PC;
      r_fetch_valid   <= 1'b0;
      r_fetch_pc      <= '0;
      r_fetch_pc_next <= '0;
    end else begin
      // NOTE: default first so every non-accepting path drops fetch_valid
      // without repeating the assignment in each branch.
      r_fetch_valid <= 1'b0;
      case (r_state)
        RST_WAIT: r_state <= FETCH;
        FETCH: begin
          if (w_halt) begin
            r_state <= HALTED;
          end else if (redirect) begin
            r_pc    <= w_target;
            r_state <= stall ? STALLED : FETCH;
          end else if (stall) begin
            r_state <= STALLED;
          end else if (imem_ack) begin
            r_pc            <= w_pc_sum;
            r_fetch_valid   <= 1'b1;
            r_fetch_pc      <= r_pc;
            r_fetch_pc_next <= w_pc_sum;
          end
        end
        STALLED: begin
          if (w_halt) begin
            r_state <= HALTED;
          end else if (redirect) begin
            r_pc    <= w_target;
            r_state <= stall ? STALLED : FETCH;
          end else if (!stall) begin
            r_state <= FETCH;
          end
        end
`ifdef IF_PC_HALT_EN
        HALTED: r_state <= HALTED;
`endif
        default: r_state <= RST_WAIT;
      endcase
    end
  end

  assign imem_req      = (r_state == FETCH);
  assign imem_addr     = r_pc;
  assign fetch_valid   = r_fetch_valid;
  assign fetch_pc      = r_fetch_pc;
  assign fetch_pc_next = r_fetch_pc_next;

endmodule

// File: tb/tb_if_pc_sequencer.sv
// Directed bench for if_pc_sequencer (B=32, PC_STEP=4, RESET_PC=0).
module tb_if_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [31:0] redirect_target;
  logic        imem_req, fetch_valid;
  logic [31:0] imem_addr, fetch_pc, fetch_pc_next;
`ifdef IF_PC_HALT_EN
  logic        halt = 1'b0;
`endif

  int vectors    = 0;
  int miscompares = 0;

  if_pc_sequencer #(.B(32), .PC_STEP(4), .RESET_PC(32'h0)) dut (
    .clk             (clk),
    .reset           (reset),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_ack        (imem_ack),
`ifdef IF_PC_HALT_EN
    .halt            (halt),
`endif
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .fetch_valid     (fetch_valid),
    .fetch_pc        (fetch_pc),
    .fetch_pc_next   (fetch_pc_next)
  );

  always #5 clk = ~clk;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; redirect_target = '0;
    step(); step();
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b want 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
    vectors++; if (fetch_pc !== 32'h0 || fetch_pc_next !== 32'h0) begin miscompares++; $display("FAIL rst_fetch: got %h/%h want 0/0", fetch_pc, fetch_pc_next); end
    // Cycle 1 after release: quiet, ack ignored.
    reset = 1'b0; imem_ack = 1'b1;
    vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL quiet_req: got %b want 0", imem_req); end
    step();
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL first_req: got %b want 1", imem_req); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL first_valid: got %b want 0", fetch_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 1; i <= 4; i++) begin
      step();
      vectors++; if (imem_addr !== 32'(4*i)) begin miscompares++; $display("FAIL b2b_addr[%0d]: got %h want %h", i, imem_addr, 32'(4*i)); end
      vectors++; if (fetch_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, fetch_valid); end
      vectors++; if (fetch_pc !== 32'(4*(i-1))) begin miscompares++; $display("FAIL b2b_pc[%0d]: got %h want %h", i, fetch_pc, 32'(4*(i-1))); end
      vectors++; if (fetch_pc_next !== 32'(4*i)) begin miscompares++; $display("FAIL b2b_next[%0d]: got %h want %h", i, fetch_pc_next, 32'(4*i)); end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL stall_req[%0d]: got %b want 0", i, imem_req); end
      vectors++; if (imem_addr !== 32'h10) begin miscompares++; $display("FAIL stall_addr[%0d]: got %h want 10", i, imem_addr); end
      vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL stall_valid[%0d]: got %b want 0", i, fetch_valid); end
    end
    stall = 1'b0;
    step();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin miscompares++; $display("FAIL release: got req=%b addr=%h want 1/10", imem_req, imem_addr); end
    vectors++; if (fetch_valid !== 1'b0) begin miscompares++; $display("FAIL release_valid: got %b want 0", fetch_valid); end
    step();
    vectors++; if (imem_addr !== 32'h14 || fetch_valid !== 1'b1 || fetch_pc !== 32'h10) begin miscompares++; $display("FAIL after_release: got addr=%h v=%b pc=%h want 14/1/10", imem_addr, fetch_valid, fetch_pc); end
  endtask

  task automatic test_redirect_ack();
    redirect = 1'b1; redirect_target = 32'h40;
    step();
    vectors++; if (imem_addr !== 32'h40 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL redir40: got addr=%h v=%b want 40/0", imem_addr, fetch_valid); end
    redirect_target = 32'h203;
    step();
    vectors++; if (imem_addr !== 32'h200) begin miscompares++; $display("FAIL redir_align: got %h want 200", imem_addr); end
    vectors++; if (fetch_valid !== 1'b0 || fetch_pc !== 32'h10) begin miscompares++; $display("FAIL redir_discard: got v=%b pc=%h want 0/10", fetch_valid, fetch_pc); end
    redirect = 1'b0; imem_ack = 1'b0;
    step();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL no_ack_hold: got req=%b addr=%h v=%b want 1/200/0", imem_req, imem_addr, fetch_valid); end
    imem_ack = 1'b1;
    step();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h200 || fetch_pc_next !== 32'h204) begin miscompares++; $display("FAIL post_redir: got v=%b pc=%h nx=%h want 1/200/204", fetch_valid, fetch_pc, fetch_pc_next); end
  endtask

  task automatic test_redirect_stall();
    imem_ack = 1'b0; redirect = 1'b1; stall = 1'b1; redirect_target = 32'h300;
    step();
    vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h300) begin miscompares++; $display("FAIL redir_stall: got req=%b addr=%h want 0/300", imem_req, imem_addr); end
    stall = 1'b0; redirect_target = 32'h405;
    step();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h404) begin miscompares++; $display("FAIL stalled_redir: got req=%b addr=%h want 1/404", imem_req, imem_addr); end
    redirect = 1'b0;
  endtask

  task automatic test_wrap();
    redirect = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0; imem_ack = 1'b1;
    vectors++; if (imem_addr !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pre: got %h want fffffffc", imem_addr); end
    step();
    vectors++; if (imem_addr !== 32'h0) begin miscompares++; $display("FAIL wrap_pc: got %h want 0", imem_addr); end
    vectors++; if (fetch_pc !== 32'hFFFF_FFFC || fetch_pc_next !== 32'h0) begin miscompares++; $display("FAIL wrap_fetch: got %h/%h want fffffffc/0", fetch_pc, fetch_pc_next); end
  endtask

  task automatic test_reset_mid_fetch();
    redirect = 1'b1; redirect_target = 32'h500; imem_ack = 1'b1; reset = 1'b1;
    vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL pre_reset_req: got %b want 1", imem_req); end
    step();
    vectors++; if (imem_addr !== 32'h0 || imem_req !== 1'b0 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL mid_reset: got addr=%h req=%b v=%b want 0/0/0", imem_addr, imem_req, fetch_valid); end
    vectors++; if (fetch_pc !== 32'h0 || fetch_pc_next !== 32'h0) begin miscompares++; $display("FAIL mid_reset_fetch: got %h/%h want 0/0", fetch_pc, fetch_pc_next); end
    reset = 1'b0; redirect = 1'b0;
    step();
    vectors++; if (imem_req !== 1'b1 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL rerun_req: got req=%b v=%b want 1/0", imem_req, fetch_valid); end
    step();
    vectors++; if (fetch_valid !== 1'b1 || fetch_pc !== 32'h0 || imem_addr !== 32'h4) begin miscompares++; $display("FAIL rerun_fetch: got v=%b pc=%h addr=%h want 1/0/4", fetch_valid, fetch_pc, imem_addr); end
  endtask

`ifdef IF_PC_HALT_EN
  task automatic test_halt();
    redirect = 1'b1; redirect_target = 32'h80; imem_ack = 1'b0;
    step();
    halt = 1'b1; redirect_target = 32'h100; imem_ack = 1'b1;
    step();
    halt = 1'b0; redirect = 1'b0;
    for (int i = 0; i < 5; i++) begin
      vectors++; if (imem_req !== 1'b0 || imem_addr !== 32'h80 || fetch_valid !== 1'b0) begin miscompares++; $display("FAIL halted[%0d]: got req=%b addr=%h v=%b want 0/80/0", i, imem_req, imem_addr, fetch_valid); end
      step();
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin miscompares++; $display("FAIL halt_exit: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect_ack();
    test_redirect_stall();
    test_wrap();
    test_reset_mid_fetch();
`ifdef IF_PC_HALT_EN
    test_halt();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
